// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the multi-cycle signed divider.
package div_unit_pkg;

   localparam int          DIV_WIDTH = 32;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_unit_if.sv
// Handshake and operand/result bus between the execute stage and the divider.
interface div_unit_if #(
   parameter int WIDTH = 32
) ();

   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;

   modport master (
      output ctrl_DIV, data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY
   );

   modport slave (
      input  ctrl_DIV, data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY
   );

endinterface

// File: rtl/div_negate.sv
// Combinational two's-complement negator: y = ~a + 1.
module div_negate #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);

   assign y = ~a + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/div_unit.sv
// Restoring signed divider: one quotient bit per cycle on operand magnitudes,
// result ready 33 cycles after start; divide-by-zero and overflow finish in one.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic       clock,
   input  logic       reset,
   div_unit_if.slave  bus
);

   localparam logic [WIDTH-1:0] MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] r;
   logic             sign;
   logic [CNT_W-1:0] counter;

   logic [WIDTH-1:0] neg_a;
   logic [WIDTH-1:0] neg_b;
   logic [WIDTH-1:0] neg_q;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] r_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] q_fix;

   logic             div_zero;
   logic             div_ovf;
   logic             load_op;
   logic             load_exc;
   logic             finish;

   logic [WIDTH-1:0] result;
   logic             exception;

   div_negate #(.WIDTH(WIDTH)) u_neg_a (.a(bus.data_operandA), .y(neg_a));
   div_negate #(.WIDTH(WIDTH)) u_neg_b (.a(bus.data_operandB), .y(neg_b));
   div_negate #(.WIDTH(WIDTH)) u_neg_q (.a(q_nxt),             .y(neg_q));

   assign abs_a = bus.data_operandA[WIDTH-1] ? neg_a : bus.data_operandA;
   assign abs_b = bus.data_operandB[WIDTH-1] ? neg_b : bus.data_operandB;

   assign div_zero = (bus.data_operandB == '0);
   assign div_ovf  = (bus.data_operandA == MIN_INT) && (bus.data_operandB == '1);

   // The remainder stays below the divisor (<= 2^(WIDTH-1)), so only the
   // shifted trial value needs the extra bit to avoid wrap.
   assign r_shift = {r, q[WIDTH-1]};
   assign trial   = r_shift - {1'b0, d};
   assign r_nxt   = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
   assign q_nxt   = {q[WIDTH-2:0], ~trial[WIDTH]};
   assign q_fix   = sign ? neg_q : q_nxt;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A start pulse wins in every state: it aborts RUN and chains out of DONE.
   always_comb begin
      state_nxt = state;
      load_op   = 1'b0;
      load_exc  = 1'b0;
      finish    = 1'b0;
      if (bus.ctrl_DIV) begin
         if (div_zero || div_ovf) begin
            state_nxt = DONE;
            load_exc  = 1'b1;
         end else begin
            state_nxt = RUN;
            load_op   = 1'b1;
         end
      end else begin
         case (state)
            IDLE: state_nxt = IDLE;
            RUN: begin
               if (counter == LAST_ITER) begin
                  state_nxt = DONE;
                  finish    = 1'b1;
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q         <= '0;
         d         <= '0;
         r         <= '0;
         sign      <= 1'b0;
         counter   <= '0;
         result    <= '0;
         exception <= 1'b0;
      end else begin
         if (load_op) begin
            q       <= abs_a;
            d       <= abs_b;
            r       <= '0;
            sign    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            counter <= '0;
         end else if (state == RUN) begin
            q       <= q_nxt;
            r       <= r_nxt;
            counter <= counter + 1'b1;
         end

         if (load_exc) begin
            result    <= div_ovf ? MIN_INT : '0;
            exception <= 1'b1;
         end else if (finish) begin
            result    <= q_fix;
            exception <= 1'b0;
         end
      end
   end

   assign bus.data_result    = result;
   assign bus.data_exception = exception;
   assign bus.data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, multi-cycle corner sequences and
// random operands checked against a plain-arithmetic signed division model.
module tb_div_unit;
   import div_unit_pkg::*;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fail;

   div_unit_if #(.WIDTH(32)) bus ();

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: truncating signed division, with the two exception cases.
   function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      int qq;
      if (b == 32'd0) return {1'b1, 32'd0};
      if (a == INT_MIN && b == 32'hFFFF_FFFF) return {1'b1, INT_MIN};
      sa = a;
      sb = b;
      qq = sa / sb;
      return {1'b0, 32'(qq)};
   endfunction

   // Issue a start and count edges (start edge = 1) until RDY is seen.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic exc, output int lat);
      @(negedge clock);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      bus.ctrl_DIV = 1'b0;
      lat = 1;
      while (bus.data_resultRDY !== 1'b1 && lat < 100) begin
         @(posedge clock);
         #1;
         lat++;
      end
      res = bus.data_result;
      exc = bus.data_exception;
   endtask

   task automatic do_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eres, input logic eexc, input int elat,
                         input bit chk_pulse);
      logic [31:0] res;
      logic        exc;
      int          lat;
      run_div(a, b, res, exc, lat);
      check({name, ".lat"}, 32'(lat), 32'(elat));
      check({name, ".res"}, res, eres);
      check({name, ".exc"}, {31'd0, exc}, {31'd0, eexc});
      if (chk_pulse) begin
         @(posedge clock);
         #1;
         check({name, ".pulse"}, {31'd0, bus.data_resultRDY}, 32'd0);
      end
   endtask

   task automatic count_rdy(input int cycles, inout int pulses);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY === 1'b1) pulses++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pulses;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [32:0] exp;

      n_checks          = 0;
      n_fail            = 0;
      reset             = 1'b1;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;

      vecs[0]  = '{"basic",     32'd100,         32'd7,           32'd14,          1'b0, 33};
      vecs[1]  = '{"neg_a",     -32'sd100,       32'd7,           32'hFFFF_FFF2,   1'b0, 33};
      vecs[2]  = '{"neg_b",     32'd100,         -32'sd7,         32'hFFFF_FFF2,   1'b0, 33};
      vecs[3]  = '{"neg_ab",    -32'sd100,       -32'sd7,         32'd14,          1'b0, 33};
      vecs[4]  = '{"zero_q",    32'd3,           -32'sd5,         32'd0,           1'b0, 33};
      vecs[5]  = '{"div0",      32'd5,           32'd0,           32'd0,           1'b1, 1};
      vecs[6]  = '{"after0",    32'd6,           32'd3,           32'd2,           1'b0, 33};
      vecs[7]  = '{"ovf",       INT_MIN,         32'hFFFF_FFFF,   INT_MIN,         1'b1, 1};
      vecs[8]  = '{"min_by1",   INT_MIN,         32'd1,           INT_MIN,         1'b0, 33};
      vecs[9]  = '{"max_bymin", 32'h7FFF_FFFF,   INT_MIN,         32'd0,           1'b0, 33};
      vecs[10] = '{"min_bymin", INT_MIN,         INT_MIN,         32'd1,           1'b0, 33};
      vecs[11] = '{"min_by2",   INT_MIN,         32'd2,           32'hC000_0000,   1'b0, 33};

      repeat (2) @(posedge clock);
      #1;
      check("reset.rdy", {31'd0, bus.data_resultRDY}, 32'd0);
      check("reset.res", bus.data_result, 32'd0);
      check("reset.exc", {31'd0, bus.data_exception}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 12; i++)
         do_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, vecs[i].lat, 1'b1);

      // Abort: second start 10 cycles into the first; only one RDY expected.
      pulses = 0;
      @(negedge clock);
      bus.data_operandA = 32'd1000;
      bus.data_operandB = 32'd10;
      bus.ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      bus.ctrl_DIV = 1'b0;
      count_rdy(8, pulses);
      do_vec("abort", 32'd81, 32'd9, 32'd9, 1'b0, 33, 1'b1);
      count_rdy(40, pulses);
      check("abort.extra_rdy", 32'(pulses), 32'd0);

      // Reset mid-run clears outputs and suppresses RDY.
      pulses = 0;
      @(negedge clock);
      bus.data_operandA = 32'd1000;
      bus.data_operandB = 32'd10;
      bus.ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      bus.ctrl_DIV = 1'b0;
      count_rdy(10, pulses);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      count_rdy(40, pulses);
      check("rst_mid.rdy", 32'(pulses), 32'd0);
      check("rst_mid.res", bus.data_result, 32'd0);
      check("rst_mid.exc", {31'd0, bus.data_exception}, 32'd0);
      do_vec("rst_after", 32'd1000, 32'd10, 32'd100, 1'b0, 33, 1'b1);

      // Reset and start on the same edge: start is dropped.
      pulses = 0;
      @(negedge clock);
      bus.data_operandA = 32'd50;
      bus.data_operandB = 32'd5;
      bus.ctrl_DIV      = 1'b1;
      reset             = 1'b1;
      @(posedge clock);
      #1;
      bus.ctrl_DIV = 1'b0;
      reset        = 1'b0;
      count_rdy(40, pulses);
      check("rst_start.rdy", 32'(pulses), 32'd0);
      check("rst_start.res", bus.data_result, 32'd0);

      // Starts issued during DONE chain directly (DONE->RUN, DONE->DONE).
      do_vec("chain1", 32'd1000, 32'd10, 32'd100, 1'b0, 33, 1'b0);
      do_vec("chain2", -32'sd81, 32'd9, 32'hFFFF_FFF7, 1'b0, 33, 1'b0);
      do_vec("chain3", 32'd7, 32'd0, 32'd0, 1'b1, 1, 1'b0);
      do_vec("chain4", INT_MIN, 32'hFFFF_FFFF, INT_MIN, 1'b1, 1, 1'b0);
      do_vec("chain5", 32'd77, 32'd7, 32'd11, 1'b0, 33, 1'b1);

      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: begin ra = INT_MIN; rb = 32'hFFFF_FFFF; end
            2, 3: begin
               rb = 32'($urandom_range(1, 20));
               if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            default: ;
         endcase
         exp = ref_div(ra, rb);
         do_vec($sformatf("rand%0d", i), ra, rb, exp[31:0], exp[32], exp[32] ? 1 : 33,
                (i % 2) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
